// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM output path: fade state encoding and default duty width.
package pdm_pkg;

  localparam int unsigned DUTY_BITS_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } fade_state_e;

endpackage

// File: rtl/pdm_tick_gen.sv
// Programmable prescaler: counts 0..period while enabled and flags the terminal count.
module pdm_tick_gen #(
  parameter int unsigned PERIOD_BITS = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   en,
  input  logic [PERIOD_BITS-1:0] period,
  output logic                   tick_c
);

  logic [PERIOD_BITS-1:0] cnt_q;

  assign tick_c = en && (cnt_q == period);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick_c ? '0 : cnt_q + PERIOD_BITS'(1);
    end
  end

endmodule

// File: rtl/pdm_fade.sv
// Slew-limited duty generator: ramps duty toward a loaded target one step per prescaler tick,
// optionally breathing between 0 and the target.
module pdm_fade
  import pdm_pkg::*;
#(
  parameter int unsigned DUTY_BITS   = DUTY_BITS_DEFAULT,
  parameter int unsigned PERIOD_BITS = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   stop,
  input  logic [DUTY_BITS-1:0]   target,
  input  logic [DUTY_BITS-1:0]   step,
  input  logic [PERIOD_BITS-1:0] period,
  input  logic                   breathe,
  output logic [DUTY_BITS-1:0]   duty,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned DIFF_BITS = DUTY_BITS + 1;

  fade_state_e            state_q, state_d;
  logic [DUTY_BITS-1:0]   duty_q, duty_d;
  logic [DUTY_BITS-1:0]   target_q, target_d;
  logic [DUTY_BITS-1:0]   step_q, step_d;
  logic [PERIOD_BITS-1:0] period_q, period_d;
  logic                   breathe_q, breathe_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;

  logic                   tick;
  logic [DUTY_BITS-1:0]   floor_val;
  logic [DIFF_BITS-1:0]   diff_up, diff_dn, step_ext;

  pdm_tick_gen #(
    .PERIOD_BITS(PERIOD_BITS)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clr   (load | stop),
    .en    (state_q != IDLE),
    .period(period_q),
    .tick_c(tick)
  );

  // Distances to the endpoint in one extra bit so the saturation test never wraps.
  assign floor_val = breathe_q ? '0 : target_q;
  assign diff_up   = DIFF_BITS'(target_q) - DIFF_BITS'(duty_q);
  assign diff_dn   = DIFF_BITS'(duty_q) - DIFF_BITS'(floor_val);
  assign step_ext  = DIFF_BITS'(step_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      duty_q    <= '0;
      target_q  <= '0;
      step_q    <= '0;
      period_q  <= '0;
      breathe_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      duty_q    <= duty_d;
      target_q  <= target_d;
      step_q    <= step_d;
      period_q  <= period_d;
      breathe_q <= breathe_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    target_d  = target_q;
    step_d    = step_q;
    period_d  = period_q;
    breathe_d = breathe_q;
    done_d    = 1'b0;

    if (load) begin
      target_d  = target;
      step_d    = (step == '0) ? DUTY_BITS'(1) : step;
      period_d  = period;
      breathe_d = breathe;
      if (target > duty_q) begin
        state_d = UP;
      end else if (target < duty_q) begin
        state_d = DOWN;
      end else if (breathe && (target != '0)) begin
        state_d = DOWN;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if (stop) begin
      state_d = IDLE;
    end else if (tick) begin
      case (state_q)
        UP: begin
          if (diff_up <= step_ext) begin
            duty_d = target_q;
            if (breathe_q) begin
              state_d = DOWN;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            duty_d = duty_q + step_q;
          end
        end
        DOWN: begin
          // Breathe reports one done per cycle, on arrival at zero.
          if (diff_dn <= step_ext) begin
            duty_d  = floor_val;
            done_d  = 1'b1;
            state_d = breathe_q ? UP : IDLE;
          end else begin
            duty_d = duty_q - step_q;
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  assign duty = duty_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_pdm_fade.sv
// Self-checking bench for pdm_fade: directed and random ramps checked cycle by cycle
// against an expected duty timeline built from the ramp rules.
module tb_pdm_fade;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic        stop;
  logic [7:0]  target;
  logic [7:0]  step;
  logic [15:0] period;
  logic        breathe;
  logic [7:0]  duty;
  logic        busy;
  logic        done;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  model_duty;

  pdm_fade #(
    .DUTY_BITS  (8),
    .PERIOD_BITS(16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .stop   (stop),
    .target (target),
    .step   (step),
    .period (period),
    .breathe(breathe),
    .duty   (duty),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_duty"}, 16'(duty), 16'(model_duty));
    chk({tag, "_busy"}, 16'(busy), 16'd0);
    chk({tag, "_done"}, 16'(done), 16'd0);
  endtask

  // Load a ramp and check every cycle against a precomputed timeline of tick values.
  // limit=0 runs a one-shot ramp to completion; otherwise only 'limit' cycles are checked
  // and the caller follows up with another load or a stop.
  task automatic run(input logic [7:0] t, input logic [7:0] s, input logic [15:0] p,
                     input bit b, input bit with_stop, input int limit);
    logic [7:0] vals[$];
    bit         dns[$];
    logic [7:0] start, cur, se, exp_duty;
    bit         up, imm, exp_done, exp_busy;
    int         per, nt, kk, idx, cf, ncyc;

    start = model_duty;
    cur   = start;
    se    = (s == 8'd0) ? 8'd1 : s;
    per   = int'(p) + 1;
    imm   = (t == start) && (!b || t == 8'd0);
    up    = (t > start);

    if (!imm && !b) begin
      while (cur != t) begin
        if (up) cur = (int'(t) - int'(cur) <= int'(se)) ? t : cur + se;
        else    cur = (int'(cur) - int'(t) <= int'(se)) ? t : cur - se;
        vals.push_back(cur);
        dns.push_back(cur == t);
      end
    end else if (!imm) begin
      nt = limit / per + 2;
      for (int i = 0; i < nt; i++) begin
        if (up) begin
          if (int'(t) - int'(cur) <= int'(se)) begin cur = t; up = 1'b0; end
          else cur = cur + se;
          vals.push_back(cur);
          dns.push_back(1'b0);
        end else begin
          if (int'(cur) <= int'(se)) begin cur = 8'd0; up = 1'b1; dns.push_back(1'b1); end
          else begin cur = cur - se; dns.push_back(1'b0); end
          vals.push_back(cur);
        end
      end
    end

    cf   = 1 + vals.size() * per;
    ncyc = (b && !imm) ? limit : cf + 2;
    if (limit > 0 && limit < ncyc) ncyc = limit;

    target  = t;
    step    = s;
    period  = p;
    breathe = b;
    load    = 1'b1;
    stop    = with_stop;
    cyc();
    load    = 1'b0;
    stop    = 1'b0;
    target  = 8'($urandom);
    step    = 8'($urandom);
    period  = 16'($urandom);
    breathe = 1'($urandom);

    exp_duty = start;
    for (int c = 1; c <= ncyc; c++) begin
      kk  = (c - 1) / per;
      idx = (kk > vals.size()) ? vals.size() : kk;
      exp_duty = (idx == 0) ? start : vals[idx-1];
      if (imm) exp_done = (c == 1);
      else     exp_done = (kk >= 1) && (kk <= vals.size()) && ((c - 1) % per == 0) && dns[kk-1];
      exp_busy = (b && !imm) ? 1'b1 : (c < cf);
      chk("ramp_duty", 16'(duty), 16'(exp_duty));
      chk("ramp_done", 16'(done), 16'(exp_done));
      chk("ramp_busy", 16'(busy), 16'(exp_busy));
      if (c < ncyc) cyc();
    end
    model_duty = exp_duty;
  endtask

  // Stop strobe: duty must freeze, busy drop, and no done appear.
  task automatic do_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_idle("stop");
      cyc();
    end
  endtask

  initial begin
    rst     = 1'b1;
    load    = 1'b0;
    stop    = 1'b0;
    target  = 8'd0;
    step    = 8'd0;
    period  = 16'd0;
    breathe = 1'b0;
    model_duty = 8'd0;
    repeat (3) cyc();
    rst = 1'b0;

    chk_idle("reset");
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk_idle("idle");
    end
    cyc();

    run(8'd200, 8'd50, 16'd3, 1'b0, 1'b0, 0);
    cyc();
    run(8'd10, 8'd64, 16'd0, 1'b0, 1'b0, 0);
    cyc();
    run(8'd250, 8'd255, 16'd0, 1'b0, 1'b0, 0);
    cyc();
    run(8'd255, 8'd0, 16'd0, 1'b0, 1'b0, 0);
    cyc();
    run(8'd255, 8'd9, 16'd2, 1'b0, 1'b0, 0);
    cyc();

    run(8'd0, 8'd255, 16'd0, 1'b0, 1'b0, 0);
    cyc();
    run(8'd4, 8'd2, 16'd0, 1'b1, 1'b0, 6);
    do_stop();

    run(8'd100, 8'd7, 16'd1, 1'b0, 1'b1, 0);
    cyc();

    // Retarget mid-ramp, then reset mid-ramp.
    run(8'd0, 8'd3, 16'd0, 1'b0, 1'b0, 9);
    run(8'd200, 8'd1, 16'd0, 1'b0, 1'b0, 5);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    model_duty = 8'd0;
    for (int i = 0; i < 4; i++) begin
      chk_idle("midreset");
      cyc();
    end

    for (int i = 0; i < 8; i++) begin
      run(8'($urandom), 8'($urandom_range(0, 60)), 16'($urandom_range(0, 3)), 1'b0, 1'b0,
          ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 25)));
    end
    cyc();
    for (int i = 0; i < 3; i++) begin
      run(8'($urandom_range(1, 255)), 8'($urandom_range(0, 80)), 16'($urandom_range(0, 2)),
          1'b1, 1'b0, int'($urandom_range(10, 60)));
      do_stop();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
